jk_seq_ctrl: RTL

Sequencer for the 4-bit JK flip-flop bank. It is programmed with DEPTH command words, each a J nibble and a K nibble, and replays them into the bank's J/K inputs. Each step is held for a programmable dwell, the sequence runs one-shot or looped, and an optional clear pulse can precede it. It sits between the board switches/keys and the flip-flop bank, replacing the direct switch-to-J/K wiring with a timed, repeatable stimulus source.

---
 rtl/jk_seq_ctrl.sv | 124 ++++++++++++
 1 files changed

// File: rtl/jk_seq_ctrl.sv
// Timed J/K command sequencer for a WIDTH-bit JK flip-flop bank, one-shot or looped replay.
// Optional pre-sequence clear pulse compiled in with JK_SEQ_INIT_CLR_EN.
module jk_seq_ctrl #(
  parameter int WIDTH   = 4,
  parameter int DEPTH   = 4,
  parameter int DWELL_W = 8
) (
  input  logic                     CLK,
  input  logic                     Rst,
  input  logic [2*WIDTH-1:0]       Sw_In,
  input  logic                     Load,
  input  logic                     Start,
  input  logic                     Stop,
  input  logic                     Loop,
  input  logic [DWELL_W-1:0]       Dwell,
  output logic [WIDTH-1:0]         J,
  output logic [WIDTH-1:0]         K,
  output logic                     Clrn,
  output logic                     Busy,
  output logic                     Done,
  output logic [$clog2(DEPTH)-1:0] Step
);

  localparam int SW = $clog2(DEPTH);
  localparam logic [SW-1:0] LAST = SW'(DEPTH - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
`ifdef JK_SEQ_INIT_CLR_EN
  localparam logic [1:0] ST_INIT = 2'd1;
`endif
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0]         st;
  logic [2*WIDTH-1:0] slot [DEPTH];
  logic [SW-1:0]      wptr;
  logic [DWELL_W-1:0] cnt;
  logic [DWELL_W-1:0] dwell_lat;
  logic               loop_lat;

  always_ff @(posedge CLK) begin
    if (Rst) begin
      st        <= ST_IDLE;
      J         <= '0;
      K         <= '0;
      Clrn      <= 1'b1;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      Step      <= '0;
      wptr      <= '0;
      cnt       <= '0;
      dwell_lat <= '0;
      loop_lat  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) slot[i] <= '0;
    end else begin
      Done <= 1'b0;
      case (st)
        ST_IDLE: begin
          // Start outranks Load, Stop outranks Start
          if (Start && !Stop) begin
            loop_lat  <= Loop;
            dwell_lat <= Dwell;
            Busy      <= 1'b1;
            Step      <= '0;
`ifdef JK_SEQ_INIT_CLR_EN
            st        <= ST_INIT;
            Clrn      <= 1'b0;
`else
            st        <= ST_RUN;
            {J, K}    <= slot[0];
            cnt       <= Dwell;
`endif
          end else if (Load && !Start) begin
            slot[wptr] <= Sw_In;
            wptr       <= wptr + 1'b1;
          end
        end
`ifdef JK_SEQ_INIT_CLR_EN
        ST_INIT: begin
          Clrn <= 1'b1;
          if (Stop) begin
            st   <= ST_IDLE;
            Busy <= 1'b0;
          end else begin
            st     <= ST_RUN;
            {J, K} <= slot[0];
            cnt    <= dwell_lat;
          end
        end
`endif
        ST_RUN: begin
          if (Stop) begin
            st   <= ST_IDLE;
            J    <= '0;
            K    <= '0;
            Busy <= 1'b0;
            Step <= '0;
          end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (Step != LAST) begin
            Step   <= Step + 1'b1;
            {J, K} <= slot[Step + 1'b1];
            cnt    <= dwell_lat;
          end else if (loop_lat) begin
            // wrap straight back to slot 0, no idle gap
            Step   <= '0;
            {J, K} <= slot[0];
            cnt    <= dwell_lat;
          end else begin
            st   <= ST_DONE;
            J    <= '0;
            K    <= '0;
            Busy <= 1'b0;
            Done <= 1'b1;
            Step <= '0;
          end
        end
        ST_DONE: st <= ST_IDLE;
        default: st <= ST_IDLE;
      endcase
    end
  end

endmodule
